ncl_thresh_bank: RTL
====================

Name: ncl_thresh_bank

Overview:
- Clocked functional model of a bank of CH identical NCL weighted threshold gates with hysteresis (THmnWw family).
- Gate parameters (inputs, weights, threshold, hysteresis mode) are generic. Defaults reproduce a TH34W22 gate per channel.
- Adds bank-level DATA/NULL completion detection, a wavefront counter, and a per-channel input-monotonicity checker.
- Used in FPGA prototyping and in cycle-based regression of NCL pipelines where transistor-level cells cannot simulate.

Parameters:
- CH, 4, number of independent gate channels.
- N, 4, inputs per gate.
- WW, 4, bit width of each weight.
- WEIGHTS, 16'h1122, packed unsigned weights. Input i has weight WEIGHTS[i*WW +: WW], so the default gives a=2, b=2, c=1, d=1.
- M, 3, threshold. Legal range is 1 ≤ M ≤ sum of weights; violations fail elaboration.
- SW, 8, width of the weighted-sum accumulator. Must hold N*(2^WW-1) without overflow.
- HYST, 1, mode select. 1 = NCL hysteresis; 0 = plain registered threshold (no state holding).
- CW, 16, width of the wavefront counter.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, update enable. When 0, all state holds.
- din, input, CH*N, gate inputs. Channel k uses din[k*N +: N]; bit 0 is input a.
- err_clr, input, 1, clears all mono_err bits.
- y, output, CH, registered gate outputs.
- all_data, output, 1, &y (combinational from the y register).
- all_null, output, 1, ~|y (combinational from the y register).
- wave_cnt, output, CW, count of completed NULL→DATA bank wavefronts.
- mono_err, output, CH, sticky per-channel monotonicity violation flag.

Behaviour:
- Reset (rst=1 at a clock edge), which overrides en:
  - y=0, so all_null=1 and all_data=0.
  - wave_cnt=0, mono_err=0, all fall flags=0, phase FSM=NULL_PH.
- Per channel, each en=1 cycle:
  - sum = Σ w_i·din_i, computed unsigned at width SW.
  - set = (sum ≥ M); clr = (channel inputs all 0).
  - HYST=1: y_next = set ? 1 : clr ? 0 : y (hold).
  - HYST=0: y_next = set.
  - Latency is one clock from din to y.
- With the default weights and hysteresis, a channel holds 1 while any input remains high after it has set.
- Phase FSM, evaluated on the updated y (the same edge y changes):
  - NULL_PH → DATA_PH when every y_next bit is 1; wave_cnt increments, wrapping modulo 2^CW.
  - DATA_PH → NULL_PH when every y_next bit is 0.
  - Partial states hold the current phase.
  - Bouncing within a phase never double-counts.
- Monotonicity checker, per channel:
  - Track prev_din (registered din), reset to 0.
  - fall flag sets when any bit goes 1→0 versus prev_din.
  - fall flag clears when the channel's din is all 0.
  - A violation is any bit 0→1 while the fall flag is already set (a fall and a rise in the same cycle with the flag clear is not a violation, but it does set the flag).
  - A violation sets mono_err[k] on the next edge; the flag stays set until err_clr or rst.
  - If err_clr and a new violation occur in the same cycle, the new violation wins (bit ends at 1). Other bits clear.
  - The checker does not alter y.
- en=0 freezes y, FSM, wave_cnt, prev_din, fall flags and mono_err. err_clr is ignored while en=0.
- All outputs are glitch-free registers or simple reductions of the y register; no combinational path from din to any output.

Test Plan:
1. Defaults, channel 0:
   - din=a|b (sum 4) → y[0]=1 one cycle later.
   - Drop a (sum 2) → y[0] stays 1.
   - Drop b → y[0]=0 next cycle.
2. Defaults, channel 0:
   - c only (sum 1) → y[0]=0.
   - Add a (sum 3) → y[0]=1.
   - Drop a, keep c → y[0] holds 1.
   - Drop c → y[0]=0.
3. HYST=0 instance:
   - a|b → y[0]=1.
   - Drop a (sum 2) → y[0]=0 next cycle, with no hold.
4. Wavefront counting:
   - All channels: five full DATA (a|b) / NULL (0) wavefronts, with channels staggered by 1–3 cycles → wave_cnt=5.
   - CW=2 instance → wave_cnt=1 after the same sequence.
   - Partial DATA (3 of 4 channels) followed by NULL → no increment.
5. Monotonicity:
   - Channel 2: a|b, then drop b, then re-raise b → mono_err=4'b0100 one cycle after the re-raise.
   - Pulse err_clr → 0.
   - Repeat the violation in the same cycle as err_clr → bit remains 1.
6. Reset and enable:
   - Reset mid-DATA_PH with wave_cnt=3 and y=4'hF → next cycle y=0, all_null=1, wave_cnt=0, mono_err=0.
   - en=0 with changing din → y and wave_cnt unchanged.

Source files
------------

// File: rtl/ncl_thresh_bank.sv
// Bank of CH clocked NCL weighted threshold gates (THmnWw) with optional hysteresis,
// bank completion detection, NULL->DATA wavefront counting and input-monotonicity checking.
module ncl_thresh_bank #(
    parameter int unsigned          CH      = 4,
    parameter int unsigned          N       = 4,
    parameter int unsigned          WW      = 4,
    parameter logic [N*WW-1:0]      WEIGHTS = 16'h1122,
    parameter int unsigned          M       = 3,
    parameter int unsigned          SW      = 8,
    parameter bit                   HYST    = 1'b1,
    parameter int unsigned          CW      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [CH*N-1:0] din,
    input  logic            err_clr,
    output logic [CH-1:0]   y,
    output logic            all_data,
    output logic            all_null,
    output logic [CW-1:0]   wave_cnt,
    output logic [CH-1:0]   mono_err
);

    function automatic int unsigned weight_sum();
        int unsigned s;
        s = 0;
        for (int i = 0; i < N; i++) begin
            s += int'(WEIGHTS[i*WW +: WW]);
        end
        return s;
    endfunction

    if (M < 1 || M > weight_sum()) begin : g_bad_threshold
        $error("ncl_thresh_bank: threshold M outside 1..sum(WEIGHTS)");
    end
    if (SW < 32 && (N * ((2 ** WW) - 1)) >= (2 ** SW)) begin : g_bad_sum_width
        $error("ncl_thresh_bank: SW too narrow for the worst-case weighted sum");
    end

    typedef enum logic {NullPh, DataPh} phase_e;

    phase_e          phase_q, phase_d;
    logic [CW-1:0]   wave_q, wave_d;
    logic [CH-1:0]   y_q, y_d;
    logic [CH-1:0]   fall_q, fall_d;
    logic [CH-1:0]   mono_q, mono_d;
    logic [CH*N-1:0] prev_q;

    logic [SW-1:0]   sum;
    logic            set, clr, fell, rose;

    always_comb begin
        y_d    = y_q;
        fall_d = fall_q;
        mono_d = mono_q;
        sum    = '0;
        set    = 1'b0;
        clr    = 1'b0;
        fell   = 1'b0;
        rose   = 1'b0;
        for (int k = 0; k < CH; k++) begin
            sum = '0;
            for (int i = 0; i < N; i++) begin
                if (din[k*N + i]) begin
                    sum = sum + SW'(WEIGHTS[i*WW +: WW]);
                end
            end
            set    = (sum >= SW'(M));
            clr    = ~|din[k*N +: N];
            y_d[k] = HYST ? (set | (~clr & y_q[k])) : set;
            fell   = |(prev_q[k*N +: N] & ~din[k*N +: N]);
            rose   = |(~prev_q[k*N +: N] & din[k*N +: N]);
            // A rise only counts as a violation against a fall seen in an earlier cycle
            fall_d[k] = ~clr & (fall_q[k] | fell);
            mono_d[k] = (mono_q[k] & ~err_clr) | (rose & fall_q[k]);
        end
    end

    // Phase tracks the post-update outputs so a wavefront is counted on the edge it completes
    always_comb begin
        phase_d = phase_q;
        wave_d  = wave_q;
        unique case (phase_q)
            NullPh: begin
                if (&y_d) begin
                    phase_d = DataPh;
                    wave_d  = wave_q + CW'(1);
                end
            end
            DataPh: begin
                if (~|y_d) begin
                    phase_d = NullPh;
                end
            end
            default: phase_d = NullPh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= NullPh;
            wave_q  <= '0;
            y_q     <= '0;
            fall_q  <= '0;
            mono_q  <= '0;
            prev_q  <= '0;
        end else if (en) begin
            phase_q <= phase_d;
            wave_q  <= wave_d;
            y_q     <= y_d;
            fall_q  <= fall_d;
            mono_q  <= mono_d;
            prev_q  <= din;
        end
    end

    assign y        = y_q;
    assign all_data = &y_q;
    assign all_null = ~|y_q;
    assign wave_cnt = wave_q;
    assign mono_err = mono_q;

endmodule
